cr_axi4s_ib_slv: RTL
====================

Name: cr_axi4s_ib_slv

Overview:
- Inbound AXI4-stream slave for the TLV datapath; the receiving end of the cr_axi4s_mstr protocol.
- Accepts axi4s_dp_bus_t beats from an upstream master under a registered tready.
- Buffers accepted beats in a first-word-fall-through FIFO.
- Presents the buffered beats on the empty/aempty/rd/data interface that cr_tlvp consumes as tlvp_ib. Also tracks frame boundaries and reports protocol and FIFO errors.

Parameters:
- N_ENTRIES, 16: FIFO depth in beats; power of two, at least 4.
- N_AFULL_VAL, 3: slack below full at which tready deasserts; at least 1.
- N_AEMPTY_VAL, 1: aempty asserts when occupancy is at most this value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- axi4s_ib_in  in  axi4s_dp_bus_t  upstream beat (tvalid, tlast, tid, tstrb, tuser, tdata).
- axi4s_ib_out  out  axi4s_dp_rdy_t  tready to upstream.
- axi4s_out  out  axi4s_dp_bus_t  head-of-FIFO beat; tvalid = !axi4s_out_empty.
- axi4s_out_empty  out  1  FIFO empty.
- axi4s_out_aempty  out  1  occupancy <= N_AEMPTY_VAL.
- axi4s_out_rd  in  1  pop the head beat.
- axi4s_out_sop  out  1  head beat is the first beat of a frame.
- frame_cnt  out  32  count of tlast beats accepted; wraps.
- ib_error  out  3  one-cycle pulses: [0] overflow, [1] underflow, [2] tvalid dropped while ready.

Behaviour:
- Reset values (async, rst_n low):
  - tready = 0, axi4s_out_empty = 1, axi4s_out_aempty = 1.
  - axi4s_out = all zeros, axi4s_out_sop = 0, frame_cnt = 0, ib_error = 0.
  - FIFO pointers and occupancy = 0, FSM = IDLE.
- tready is a flop. Each cycle it loads (next_occupancy < N_ENTRIES - N_AFULL_VAL). It therefore first rises 1 cycle after rst_n deasserts.
- push = tvalid & tready. Write an entry of {beat, sop_flag}.
- Occupancy accounting:
  - The first pushed beat is visible on axi4s_out the next cycle; FWFT latency is 1.
  - pop = axi4s_out_rd & !empty.
  - push and pop in the same cycle leave occupancy unchanged.
  - Pointers wrap modulo N_ENTRIES.
  - Occupancy is tracked in log2(N_ENTRIES)+1 bits.
- Full guard: push while occupancy == N_ENTRIES with no same-cycle pop:
  - the beat is dropped;
  - ib_error[0] pulses;
  - state is unchanged, and the beat is not counted in frame_cnt.
- axi4s_out_rd while empty: ignored, ib_error[1] pulses.
- Deasserting tvalid while tready=0 is legal. A beat offered must be held stable by the master; the slave does not check this.
- Frame FSM:
  - IDLE: an accepted beat gets sop_flag=1. tlast=0 goes to BODY; tlast=1 stays in IDLE.
  - BODY: accepted beats get sop_flag=0. Accepted tlast=1 returns to IDLE.
  - Only accepted beats advance the FSM.
- frame_cnt increments on every accepted tlast beat and wraps from 0xFFFFFFFF to 0.
- ib_error[2] is a lint-level monitor: it pulses if a tvalid beat is seen when tready was 1 and push was blocked by the full guard. This should be unreachable in legal configurations.
- axi4s_out and axi4s_out_sop always reflect the head entry. Outputs are don't-care-free: they are held at the last popped value when empty.
- Reset mid-frame: all state, including FSM and FIFO contents, clears immediately. The first beat accepted after reset is marked sop.

Decomposition:
- Shared package (cr_structs): axi4s_dp_bus_t and axi4s_dp_rdy_t, already present.
- Shared package (cr_native_types): the ib_error bit positions as localparam constants, so cr_tlvp and the bench share them.
- Sub-module: one natural sub-module, cr_axi4s_ib_fifo. It is a parameterised FWFT FIFO with occupancy, empty and aempty, and next-occupancy output for the tready flop.
- Top level holds the tready flop, frame FSM, frame_cnt and error pulses.

Test Plan:
- Reset release with tvalid=1 held: tready=0 in the first cycle after release and 1 in the next; the first beat (tdata=0x1) appears on axi4s_out 1 cycle after acceptance with sop=1 and empty=0.
- Back-pressure, defaults, no reads: stream 20 beats. After the 13th accepted beat tready drops. Occupancy peaks at 13, never exceeds 16, and ib_error stays 0.
- Frames of 1, 3 and 5 beats, tlast on the last beat of each:
  - sop=1 on beats 1, 2 and 5 (the first beat of each frame);
  - frame_cnt = 3;
  - popped tdata order matches input exactly.
- Simultaneous push and pop at occupancy 13 for 50 cycles with random tvalid and rd: occupancy stays within ±1 of expected, and the data scoreboard matches.
- axi4s_out_rd pulse while empty: ib_error = 3'b010 for exactly one cycle; pointers and empty unchanged.
- rst_n asserted mid-frame after 2 of 4 beats: empty=1 and frame_cnt=0 asynchronously. The next accepted beat after release has sop=1.

Source files
------------

// File: rtl/cr_native_types.sv
// Native constants shared between the inbound slave, cr_tlvp and their benches.
package cr_native_types;

    // Bit positions inside the ib_error pulse vector.
    localparam int IB_ERR_W         = 3;
    localparam int IB_ERR_OVERFLOW  = 0;
    localparam int IB_ERR_UNDERFLOW = 1;
    localparam int IB_ERR_DROPPED   = 2;

    // Frame tracking: IDLE means the next accepted beat opens a frame.
    typedef enum logic {
        FRAME_IDLE = 1'b0,
        FRAME_BODY = 1'b1
    } ib_frame_state_t;

endpackage

// File: rtl/cr_structs.sv
// Shared AXI4-stream datapath types for the TLV blocks.
package cr_structs;

    localparam int AXI4S_DP_TID_W   = 1;
    localparam int AXI4S_DP_TSTRB_W = 8;
    localparam int AXI4S_DP_TUSER_W = 8;
    localparam int AXI4S_DP_TDATA_W = 64;

    typedef struct packed {
        logic                        tvalid;
        logic                        tlast;
        logic [AXI4S_DP_TID_W-1:0]   tid;
        logic [AXI4S_DP_TSTRB_W-1:0] tstrb;
        logic [AXI4S_DP_TUSER_W-1:0] tuser;
        logic [AXI4S_DP_TDATA_W-1:0] tdata;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

endpackage

// File: rtl/cr_axi4s_ib_fifo.sv
// First-word-fall-through FIFO with occupancy, empty/aempty and the
// next-cycle occupancy used by the caller to register its ready signal.
// The head output holds the last popped entry while the FIFO is empty.
module cr_axi4s_ib_fifo #(
    parameter int N_ENTRIES    = 16,
    parameter int N_AEMPTY_VAL = 1,
    parameter int DATA_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         empty,
    output logic                         aempty,
    output logic [$clog2(N_ENTRIES):0]   occupancy,
    output logic [$clog2(N_ENTRIES):0]   next_occupancy
);

    localparam int PTR_W = $clog2(N_ENTRIES);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] AEMPTY_OCC = OCC_W'(N_AEMPTY_VAL);

    logic [DATA_W-1:0] mem [N_ENTRIES];
    logic [DATA_W-1:0] hold_data;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop;

    assign empty          = (occupancy == '0);
    assign aempty         = (occupancy <= AEMPTY_OCC);
    assign pop            = rd & ~empty;
    assign next_occupancy = occupancy + OCC_W'(push) - OCC_W'(pop);
    assign rd_data        = empty ? hold_data : mem[rd_ptr];

    // Storage array; cleared on reset so the head never shows stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            wr_ptr    <= wr_ptr + PTR_W'(push);
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            occupancy <= next_occupancy;
        end
    end

    // Remember the popped entry so the head output is stable while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
        end else if (pop) begin
            hold_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/cr_axi4s_ib_slv.sv
// Inbound AXI4-stream slave: registered tready, FWFT beat buffer, frame
// start marking, tlast frame counter and registered error pulses.
module cr_axi4s_ib_slv
    import cr_structs::*;
    import cr_native_types::*;
#(
    parameter int N_ENTRIES    = 16,
    parameter int N_AFULL_VAL  = 3,
    parameter int N_AEMPTY_VAL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  axi4s_dp_bus_t       axi4s_ib_in,
    output axi4s_dp_rdy_t       axi4s_ib_out,
    output axi4s_dp_bus_t       axi4s_out,
    output logic                axi4s_out_empty,
    output logic                axi4s_out_aempty,
    input  logic                axi4s_out_rd,
    output logic                axi4s_out_sop,
    output logic [31:0]         frame_cnt,
    output logic [IB_ERR_W-1:0] ib_error
);

    localparam int OCC_W   = $clog2(N_ENTRIES) + 1;
    localparam int ENTRY_W = $bits(axi4s_dp_bus_t) + 1;
    localparam logic [OCC_W-1:0] FULL_OCC     = OCC_W'(N_ENTRIES);
    localparam logic [OCC_W-1:0] TREADY_LIMIT = OCC_W'(N_ENTRIES - N_AFULL_VAL);

    ib_frame_state_t     state;
    ib_frame_state_t     state_nxt;
    logic                tready_q;
    logic                sop_flag;
    logic                push_req;
    logic                push;
    logic                pop;
    logic                full;
    logic                overflow;
    logic [IB_ERR_W-1:0] ib_error_nxt;
    logic [ENTRY_W-1:0]  wr_entry;
    logic [ENTRY_W-1:0]  rd_entry;
    logic [OCC_W-1:0]    occupancy;
    logic [OCC_W-1:0]    next_occupancy;

    assign axi4s_ib_out.tready = tready_q;
    assign pop      = axi4s_out_rd & ~axi4s_out_empty;
    assign push_req = axi4s_ib_in.tvalid & tready_q;
    assign full     = (occupancy == FULL_OCC);
    assign push     = push_req & (~full | pop);
    assign overflow = push_req & full & ~pop;
    assign wr_entry = {axi4s_ib_in, sop_flag};

    cr_axi4s_ib_fifo #(
        .N_ENTRIES    (N_ENTRIES),
        .N_AEMPTY_VAL (N_AEMPTY_VAL),
        .DATA_W       (ENTRY_W)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (rst_n),
        .push           (push),
        .wr_data        (wr_entry),
        .rd             (axi4s_out_rd),
        .rd_data        (rd_entry),
        .empty          (axi4s_out_empty),
        .aempty         (axi4s_out_aempty),
        .occupancy      (occupancy),
        .next_occupancy (next_occupancy)
    );

    // Head beat, with tvalid derived from the FIFO state rather than storage.
    always_comb begin
        axi4s_out        = axi4s_dp_bus_t'(rd_entry[ENTRY_W-1:1]);
        axi4s_out.tvalid = ~axi4s_out_empty;
        axi4s_out_sop    = rd_entry[0];
    end

    // Frame FSM next state; only accepted beats move it.
    always_comb begin
        state_nxt = state;
        sop_flag  = (state == FRAME_IDLE);
        if (push) begin
            case (state)
                FRAME_IDLE: if (!axi4s_ib_in.tlast) state_nxt = FRAME_BODY;
                FRAME_BODY: if (axi4s_ib_in.tlast)  state_nxt = FRAME_IDLE;
                default:                            state_nxt = FRAME_IDLE;
            endcase
        end
    end

    // Error pulse sources for the next cycle.
    always_comb begin
        ib_error_nxt                   = '0;
        ib_error_nxt[IB_ERR_OVERFLOW]  = overflow;
        ib_error_nxt[IB_ERR_UNDERFLOW] = axi4s_out_rd & axi4s_out_empty;
        ib_error_nxt[IB_ERR_DROPPED]   = push_req & ~push;
    end

    // Registered ready, frame state, frame counter and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tready_q  <= 1'b0;
            state     <= FRAME_IDLE;
            frame_cnt <= '0;
            ib_error  <= '0;
        end else begin
            tready_q  <= (next_occupancy < TREADY_LIMIT);
            state     <= state_nxt;
            frame_cnt <= frame_cnt + 32'(push & axi4s_ib_in.tlast);
            ib_error  <= ib_error_nxt;
        end
    end

endmodule
